read_port_ctrl: RTL and testbench

Registered, handshaked CPU read port for the CAN controller register file, replacing the purely combinational read multiplexer. It selects one of `NUM_REGS` register words or the hardware ID by address, inserts a configurable number of wait states, and returns data with a one-cycle acknowledge. It also issues clear-on-read pulses for flagged registers and reports accesses to unmapped addresses. It sits between the CPU bus interface and the register bank.

---
 rtl/read_port_pkg.sv | 19 +
 rtl/read_sel_mux.sv | 34 +++
 rtl/read_port_ctrl.sv | 134 +++++++++++++
 tb/tb_read_port_ctrl.sv | 175 +++++++++++++++++
 4 files changed

// File: rtl/read_port_pkg.sv
// Shared types and default constants for the CAN register-file read port.
package read_port_pkg;

    localparam int DEF_DATA_W   = 16;
    localparam int DEF_ADDR_W   = 5;
    localparam int DEF_NUM_REGS = 20;
    localparam int DEF_ID_ADDR  = 20;
    localparam int CNT_W        = 4;

    localparam logic [15:0] DEF_SYSTEM_ID = 16'hCA05;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_DONE = 2'd2,
        ST_HOLD = 2'd3
    } rd_state_e;

endpackage

// File: rtl/read_sel_mux.sv
// Combinational word selection: register slice, hardware ID, or zero for
// unmapped addresses.
module read_sel_mux #(
    parameter int                DATA_W    = 16,
    parameter int                ADDR_W    = 5,
    parameter int                NUM_REGS  = 20,
    parameter int                ID_ADDR   = 20,
    parameter logic [DATA_W-1:0] SYSTEM_ID = 16'hCA05
) (
    input  logic [ADDR_W-1:0]          addr,
    input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic [DATA_W-1:0]          data,
    output logic                       unmapped
);

    localparam logic [ADDR_W-1:0] ID_A = ADDR_W'(ID_ADDR);

    logic reg_hit_s;
    logic id_hit_s;

    // AND-OR select keeps the mux free of priority chains.
    always_comb begin
        data      = {DATA_W{1'b0}};
        reg_hit_s = 1'b0;
        id_hit_s  = (addr == ID_A);
        for (int i = 0; i < NUM_REGS; i++) begin
            reg_hit_s = reg_hit_s | (addr == ADDR_W'(i));
            data      = data | ({DATA_W{addr == ADDR_W'(i)}} & regs_flat[i*DATA_W +: DATA_W]);
        end
        data     = data | ({DATA_W{id_hit_s}} & SYSTEM_ID);
        unmapped = ~(reg_hit_s | id_hit_s);
    end

endmodule

// File: rtl/read_port_ctrl.sv
// Registered, handshaked CPU read port: request capture, optional wait
// states, sampled data with one-cycle ack, clear-on-read and error pulses.
module read_port_ctrl
    import read_port_pkg::*;
#(
    parameter int                  DATA_W      = DEF_DATA_W,
    parameter int                  ADDR_W      = DEF_ADDR_W,
    parameter int                  NUM_REGS    = DEF_NUM_REGS,
    parameter int                  ID_ADDR     = DEF_ID_ADDR,
    parameter logic [DATA_W-1:0]   SYSTEM_ID   = DEF_SYSTEM_ID,
    parameter int                  WAIT_STATES = 0,
    parameter logic [NUM_REGS-1:0] CLR_MASK    = 20'h00004
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic                       rd_req,
    input  logic [ADDR_W-1:0]          address,
    input  logic [NUM_REGS*DATA_W-1:0] regs_flat,
    output logic [DATA_W-1:0]          data_out,
    output logic                       rd_ack,
    output logic [NUM_REGS-1:0]        rd_clr,
    output logic                       addr_err
);

    localparam logic [CNT_W-1:0] CNT_LOAD =
        (WAIT_STATES > 0) ? CNT_W'(WAIT_STATES - 1) : {CNT_W{1'b0}};

    rd_state_e           state_r, state_next_s;
    logic [CNT_W-1:0]    cnt_r, cnt_next_s;
    logic [ADDR_W-1:0]   addr_r, addr_next_s;
    logic [DATA_W-1:0]   data_next_s;
    logic                ack_next_s;
    logic [NUM_REGS-1:0] clr_next_s;
    logic                err_next_s;
    logic [DATA_W-1:0]   sel_data_s;
    logic                unmapped_s;
    logic [NUM_REGS-1:0] clr_sel_s;

    read_sel_mux #(
        .DATA_W    (DATA_W),
        .ADDR_W    (ADDR_W),
        .NUM_REGS  (NUM_REGS),
        .ID_ADDR   (ID_ADDR),
        .SYSTEM_ID (SYSTEM_ID)
    ) u_sel (
        .addr      (addr_r),
        .regs_flat (regs_flat),
        .data      (sel_data_s),
        .unmapped  (unmapped_s)
    );

    // One-hot clear pulse for the captured address, masked to clear-on-read registers.
    always_comb begin
        clr_sel_s = {NUM_REGS{1'b0}};
        for (int i = 0; i < NUM_REGS; i++) begin
            clr_sel_s[i] = CLR_MASK[i] & (addr_r == ADDR_W'(i));
        end
    end

    // Next-state and next-output logic of the read handshake FSM.
    always_comb begin
        state_next_s = state_r;
        cnt_next_s   = cnt_r;
        addr_next_s  = addr_r;
        data_next_s  = data_out;
        ack_next_s   = 1'b0;
        clr_next_s   = {NUM_REGS{1'b0}};
        err_next_s   = 1'b0;
        case (state_r)
            ST_IDLE: begin
                if (rd_req) begin
                    addr_next_s = address;
                    if (WAIT_STATES == 0) begin
                        state_next_s = ST_DONE;
                    end else begin
                        cnt_next_s   = CNT_LOAD;
                        state_next_s = ST_WAIT;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_WAIT: begin
                if (!rd_req) begin
                    state_next_s = ST_IDLE;
                end else if (cnt_r == {CNT_W{1'b0}}) begin
                    state_next_s = ST_DONE;
                end else begin
                    cnt_next_s = cnt_r - {{(CNT_W-1){1'b0}}, 1'b1};
                end
            end
            ST_DONE: begin
                // Sampling here, not at capture, picks up writes made during wait states.
                data_next_s  = sel_data_s;
                ack_next_s   = 1'b1;
                clr_next_s   = clr_sel_s;
                err_next_s   = unmapped_s;
                state_next_s = ST_HOLD;
            end
            ST_HOLD: begin
                if (!rd_req) begin
                    state_next_s = ST_IDLE;
                end else begin
                    state_next_s = ST_HOLD;
                end
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, counter, captured address and registered outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r  <= ST_IDLE;
            cnt_r    <= {CNT_W{1'b0}};
            addr_r   <= {ADDR_W{1'b0}};
            data_out <= {DATA_W{1'b0}};
            rd_ack   <= 1'b0;
            rd_clr   <= {NUM_REGS{1'b0}};
            addr_err <= 1'b0;
        end else begin
            state_r  <= state_next_s;
            cnt_r    <= cnt_next_s;
            addr_r   <= addr_next_s;
            data_out <= data_next_s;
            rd_ack   <= ack_next_s;
            rd_clr   <= clr_next_s;
            addr_err <= err_next_s;
        end
    end

endmodule

// File: tb/tb_read_port_ctrl.sv
// Directed bench: one instance with no wait states, one with three.
module tb_read_port_ctrl;

    logic         clock = 1'b0;
    logic         reset = 1'b0;
    logic [319:0] regs_flat = '0;

    logic         req0 = 1'b0, req3 = 1'b0;
    logic [4:0]   addr0 = 5'd0, addr3 = 5'd0;
    logic [15:0]  data0, data3;
    logic         ack0, ack3, err0, err3;
    logic [19:0]  clr0, clr3;

    int total  = 0;
    int passed = 0;

    read_port_ctrl #(.WAIT_STATES(0)) u0 (
        .clock(clock), .reset(reset), .rd_req(req0), .address(addr0),
        .regs_flat(regs_flat), .data_out(data0), .rd_ack(ack0),
        .rd_clr(clr0), .addr_err(err0)
    );

    read_port_ctrl #(.WAIT_STATES(3)) u3 (
        .clock(clock), .reset(reset), .rd_req(req3), .address(addr3),
        .regs_flat(regs_flat), .data_out(data3), .rd_ack(ack3),
        .rd_clr(clr3), .addr_err(err3)
    );

    always #5 clock = ~clock;

    task automatic step();
        @(posedge clock);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) passed++;
        else $error("FAIL %s: observed %h expected %h", tag, obs, exp);
    endtask

    // One complete zero-wait read on u0, including ack timing and release.
    task automatic read0(input logic [4:0] a, input logic [15:0] exp_d,
                         input logic [19:0] exp_c, input logic exp_e);
        req0  = 1'b1;
        addr0 = a;
        step();
        check("ws0_no_early_ack", {31'd0, ack0}, 32'd0);
        addr0 = 5'd31;
        step();
        check("ws0_ack",  {31'd0, ack0}, 32'd1);
        check("ws0_data", {16'd0, data0}, {16'd0, exp_d});
        check("ws0_clr",  {12'd0, clr0}, {12'd0, exp_c});
        check("ws0_err",  {31'd0, err0}, {31'd0, exp_e});
        req0 = 1'b0;
        step();
        check("ws0_ack_pulse",  {31'd0, ack0}, 32'd0);
        check("ws0_clr_pulse",  {12'd0, clr0}, 32'd0);
        check("ws0_err_pulse",  {31'd0, err0}, 32'd0);
        check("ws0_data_held",  {16'd0, data0}, {16'd0, exp_d});
    endtask

    initial begin
        for (int i = 0; i < 20; i++) regs_flat[i*16 +: 16] = 16'(16'h1000 + i);
        regs_flat[5*16 +: 16]  = 16'h1234;
        regs_flat[2*16 +: 16]  = 16'hBEEF;
        regs_flat[7*16 +: 16]  = 16'h0001;
        regs_flat[19*16 +: 16] = 16'h5A5A;

        step();
        step();
        check("rst_data", {16'd0, data0}, 32'd0);
        check("rst_ack",  {31'd0, ack0}, 32'd0);
        check("rst_clr",  {12'd0, clr0}, 32'd0);
        check("rst_err",  {31'd0, err0}, 32'd0);
        reset = 1'b1;
        step();

        read0(5'd5,  16'h1234, 20'h00000, 1'b0);
        read0(5'd20, 16'hCA05, 20'h00000, 1'b0);
        read0(5'd25, 16'h0000, 20'h00000, 1'b1);
        read0(5'd2,  16'hBEEF, 20'h00004, 1'b0);
        read0(5'd19, 16'h5A5A, 20'h00000, 1'b0);

        // Three wait states, register updated mid-wait.
        req3  = 1'b1;
        addr3 = 5'd7;
        step();
        addr3 = 5'd5;
        for (int c = 1; c <= 3; c++) begin
            if (c == 3) regs_flat[7*16 +: 16] = 16'h00FF;
            step();
            check("ws3_no_early_ack", {31'd0, ack3}, 32'd0);
        end
        step();
        check("ws3_ack",  {31'd0, ack3}, 32'd1);
        check("ws3_data", {16'd0, data3}, 32'h000000FF);
        check("ws3_clr",  {12'd0, clr3}, 32'd0);
        req3 = 1'b0;
        step();
        check("ws3_ack_pulse", {31'd0, ack3}, 32'd0);

        // Abort in WAIT on a clear-on-read register.
        req3  = 1'b1;
        addr3 = 5'd2;
        step();
        step();
        req3 = 1'b0;
        for (int c = 0; c < 6; c++) begin
            step();
            check("abort_ack",  {31'd0, ack3}, 32'd0);
            check("abort_clr",  {12'd0, clr3}, 32'd0);
            check("abort_data", {16'd0, data3}, 32'h000000FF);
        end
        req3  = 1'b1;
        addr3 = 5'd5;
        step();
        for (int c = 0; c < 3; c++) begin
            step();
            check("after_abort_wait", {31'd0, ack3}, 32'd0);
        end
        step();
        check("after_abort_ack",  {31'd0, ack3}, 32'd1);
        check("after_abort_data", {16'd0, data3}, 32'h00001234);
        req3 = 1'b0;
        step();

        // Reset during WAIT with request held.
        req3  = 1'b1;
        addr3 = 5'd20;
        step();
        step();
        reset = 1'b0;
        #1;
        check("midrst_data", {16'd0, data3}, 32'd0);
        check("midrst_ack",  {31'd0, ack3}, 32'd0);
        step();
        check("midrst_hold_data", {16'd0, data3}, 32'd0);
        reset = 1'b1;
        step();
        for (int c = 0; c < 3; c++) begin
            step();
            check("postrst_wait", {31'd0, ack3}, 32'd0);
        end
        step();
        check("postrst_ack",  {31'd0, ack3}, 32'd1);
        check("postrst_data", {16'd0, data3}, 32'h0000CA05);
        for (int c = 0; c < 6; c++) begin
            step();
            check("hold_no_reack", {31'd0, ack3}, 32'd0);
        end

        // Single low cycle re-arms.
        req3 = 1'b0;
        step();
        req3  = 1'b1;
        addr3 = 5'd2;
        step();
        for (int c = 0; c < 3; c++) begin
            step();
            check("rearm_wait", {31'd0, ack3}, 32'd0);
        end
        step();
        check("rearm_ack",  {31'd0, ack3}, 32'd1);
        check("rearm_data", {16'd0, data3}, 32'h0000BEEF);
        check("rearm_clr",  {12'd0, clr3}, 32'h00000004);
        req3 = 1'b0;
        step();
        check("rearm_clr_pulse", {12'd0, clr3}, 32'd0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
